booth_mult_iter: RTL and testbench
==================================

BOOTH_MULT_ITER -- requirements
Module: booth_mult_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, >= 4.
REQ-002 SHALL have input clk, 1 bit: single clock; every register updates on its rising edge.
REQ-003 SHALL have input clr, 1 bit: reset; synchronous, active-high.
REQ-004 SHALL have input start, 1 bit: request a multiply with the current operands.
REQ-005 SHALL have input is_signed, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have input m, WIDTH bits: multiplicand.
REQ-007 SHALL have input q, WIDTH bits: multiplier.
REQ-008 SHALL have output busy, 1 bit: a multiply is in progress.
REQ-009 SHALL have output done, 1 bit: one-cycle pulse marking out valid.
REQ-010 SHALL have output out, 2*WIDTH bits: product.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE or DONE; the accepting edge captures m, q and is_signed, clears the accumulator, loads the counter with N = WIDTH/2+1 and enters RUN.
REQ-013 SHALL extend the captured q and m to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when 0.
REQ-014 SHALL use radix-4 bit-pair recoding: group {q[2i+1],q[2i],q[2i-1]} with q[-1]=0, mapping 000/111->0, 001/010->+M, 011->+2M, 100->-2M, 101/110->-M.
REQ-015 SHALL retire one group per RUN edge, adding the selected digit times 4^i into the 2*WIDTH+2-bit accumulator, for exactly N edges.
REQ-016 SHALL make the latency fixed at N clocks in both modes: done=1 is visible after the Nth RUN edge (17 clocks for WIDTH=32).
REQ-017 SHALL, on the transition to DONE, register out as the low 2*WIDTH accumulator bits.
REQ-018 SHALL hold done for exactly one cycle; DONE then returns to IDLE unless start is high, in which case it re-enters RUN.
REQ-019 SHALL hold out stable from DONE until the next done pulse, including while the next multiply is running.
REQ-020 SHALL ignore start while in RUN: no change to the operands, the counter or out.
REQ-021 SHALL drive busy=1 exactly while in RUN.
REQ-022 SHALL make operand changes after capture have no effect on the product in progress.
REQ-023 SHALL produce the exact result in both modes for all operands, including the most negative signed value squared.

Reset
REQ-024 SHALL, whenever clr=1 at an edge, force state IDLE, busy=0, done=0, out=0, accumulator=0 and counter=0.
REQ-025 SHALL give clr priority over start and abort.
REQ-026 SHALL let clr abandon a multiply mid-RUN with no done pulse.
REQ-027 SHALL accept start on the first edge with clr=0.

Configuration
REQ-028 SHALL use macro BOOTH_MULT_ITER_ABORT_EN to compile in the abort feature.
REQ-029 SHALL, with BOOTH_MULT_ITER_ABORT_EN defined, add input abort (1 bit, placed after start); abort=1 in RUN returns to IDLE on that edge with no done pulse and out unchanged; abort in IDLE/DONE is ignored; start and abort together in DONE gives abort no effect and start is accepted.
REQ-030 SHALL, without BOOTH_MULT_ITER_ABORT_EN, have no abort port; a RUN ends only by completion or clr.

Structure
REQ-031 SHALL place in shared package booth_pkg: the state enum (IDLE/RUN/DONE) and the digit-select encoding constants (ZERO, POS1, POS2, NEG1, NEG2).
REQ-032 SHALL use a single combinational sub-module booth_recode (3-bit group in, digit select out); the counter, accumulator and FSM stay in booth_mult_iter.

Verification
REQ-033 SHALL cover: WIDTH=32, is_signed=1, m=7, q=-3 -> out=0xFFFF_FFFF_FFFF_FFEB, with done 17 clocks after start and busy high for 17 cycles.
REQ-034 SHALL cover: WIDTH=32, is_signed=0, m=q=0xFFFF_FFFF -> out=0xFFFF_FFFE_0000_0001; the same operands with is_signed=1 -> out=1.
REQ-035 SHALL cover: WIDTH=32, signed m=q=0x8000_0000 -> out=0x4000_0000_0000_0000; WIDTH=8, signed m=-128, q=127 -> out=0xC080 after 5 clocks.
REQ-036 SHALL cover: start with m=3, q=5; start again at RUN cycle 4 with m=9 -> single done, out=15; back-to-back start in DONE with m=2, q=6 -> out=12 after a further 17 clocks.
REQ-037 SHALL cover: clr at RUN cycle 10 -> next cycle busy=0, out=0, no done pulse; start on the following cycle completes normally.
REQ-038 SHALL cover: with BOOTH_MULT_ITER_ABORT_EN defined, abort at RUN cycle 5 after a prior result of 21 -> IDLE, no done pulse, out remains 21.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: FSM state and radix-4 digit-select encodings shared by booth_mult_iter and booth_recode.
package booth_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;
endpackage

// File: rtl/booth_recode.sv
// booth_recode: maps a 3-bit multiplier group {q[2i+1],q[2i],q[2i-1]} to a radix-4 digit select.
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] grp,
    output digit_e     sel
);
    always_comb
        sel = (grp == 3'b000 || grp == 3'b111) ? ZERO :
              (grp == 3'b011) ? POS2 :
              (grp == 3'b100) ? NEG2 :
              grp[2] ? NEG1 : POS1;
endmodule

// File: rtl/booth_mult_iter.sv
// booth_mult_iter: iterative radix-4 Booth multiplier, one digit per clock, fixed WIDTH/2+1 latency.
// Define BOOTH_MULT_ITER_ABORT_EN to add an abort input that cancels a running multiply.
module booth_mult_iter
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
`ifdef BOOTH_MULT_ITER_ABORT_EN
    input  logic               abort,
`endif
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam int AW = 2 * WIDTH + 2;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [AW-1:0]      mc_q, mc_d;
    logic [WIDTH+2:0]   qs_q, qs_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [AW-1:0]      mc2, addend;
    logic               m_ext, q_ext;
    digit_e             sel;

    booth_recode u_recode (.grp(qs_q[2:0]), .sel(sel));

    assign m_ext = is_signed & m[WIDTH-1];
    assign q_ext = is_signed & q[WIDTH-1];
    // Multiplicand is pre-shifted by 4^i, so each digit adds straight into the accumulator.
    assign mc2 = {mc_q[AW-2:0], 1'b0};
    assign addend = (sel == POS1) ? mc_q :
                    (sel == POS2) ? mc2 :
                    (sel == NEG1) ? -mc_q :
                    (sel == NEG2) ? -mc2 : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        qs_d    = qs_q;
        out_d   = out_q;
        if (state_q == RUN) begin
            acc_d = acc_q + addend;
            mc_d  = {mc_q[AW-3:0], 2'b00};
            qs_d  = {{2{qs_q[WIDTH+2]}}, qs_q[WIDTH+2:2]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                out_d   = acc_d[2*WIDTH-1:0];
            end
`ifdef BOOTH_MULT_ITER_ABORT_EN
            if (abort) begin
                state_d = IDLE;
                out_d   = out_q;
            end
`endif
        end else begin
            state_d = IDLE;
            if (start) begin
                state_d = RUN;
                acc_d   = '0;
                cnt_d   = CW'(N);
                mc_d    = {{(WIDTH+2){m_ext}}, m};
                qs_d    = {{2{q_ext}}, q, 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            qs_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            qs_q    <= qs_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign out  = out_q;
endmodule

// File: tb/tb_booth_mult_iter.sv
// tb_booth_mult_iter: directed checks of booth_mult_iter at WIDTH=32 and WIDTH=8.
// Abort checks compile in when BOOTH_MULT_ITER_ABORT_EN is defined.
module tb_booth_mult_iter;
    logic        clk = 0;
    logic        clr = 1, start = 0, is_signed = 0;
    logic [31:0] m = 0, q = 0;
    logic        busy, done;
    logic [63:0] out;
    logic        st8 = 0, s8 = 0, busy8, done8;
    logic [7:0]  m8 = 0, q8 = 0;
    logic [15:0] out8;
`ifdef BOOTH_MULT_ITER_ABORT_EN
    logic        abort = 0, abort8 = 0;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    booth_mult_iter #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start),
`ifdef BOOTH_MULT_ITER_ABORT_EN
        .abort(abort),
`endif
        .is_signed(is_signed), .m(m), .q(q), .busy(busy), .done(done), .out(out)
    );

    booth_mult_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(st8),
`ifdef BOOTH_MULT_ITER_ABORT_EN
        .abort(abort8),
`endif
        .is_signed(s8), .m(m8), .q(q8), .busy(busy8), .done(done8), .out(out8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        m = a;
        q = b;
        start = 1;
        tick();
        start = 0;
    endtask

    // Counts RUN edges from k0 until done; checks total latency, busy cycles and product.
    task automatic wait_done(input string tag, input int k0, input logic [63:0] exp);
        int k = k0;
        int nb = 0;
        while (!done && k < 40) begin
            if (busy) nb++;
            tick();
            k++;
        end
        chk({tag, "_lat"}, 64'(k), 64'd17);
        if (k0 == 0) chk({tag, "_busy_cycles"}, 64'(nb), 64'd17);
        chk({tag, "_out"}, out, exp);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_out8", 64'(out8), 64'd0);
        clr = 0;
        go(1, 32'd7, 32'hFFFF_FFFD);
        wait_done("s7xm3", 0, 64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        chk("done_pulse", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        go(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("u_max_sq", 0, 64'hFFFF_FFFE_0000_0001);
        tick();
        go(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("s_m1_sq", 0, 64'd1);
        tick();
        go(1, 32'h8000_0000, 32'h8000_0000);
        wait_done("s_min_sq", 0, 64'h4000_0000_0000_0000);
        tick();
        go(0, 32'h1234_5678, 32'h10);
        wait_done("u_shift", 0, 64'h1_2345_6780);
        tick();
        s8 = 1;
        m8 = 8'h80;
        q8 = 8'h7F;
        st8 = 1;
        tick();
        st8 = 0;
        begin
            int k = 0;
            while (!done8 && k < 20) begin
                tick();
                k++;
            end
            chk("w8_lat", 64'(k), 64'd5);
            chk("w8_out", 64'(out8), 64'h0000_0000_0000_C080);
        end
        go(0, 32'd3, 32'd5);
        tick();
        tick();
        tick();
        go(0, 32'd9, 32'd5);
        chk("ign_start_busy", 64'(busy), 64'd1);
        wait_done("ign_start", 4, 64'd15);
        go(0, 32'd2, 32'd6);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_hold", out, 64'd15);
        wait_done("b2b", 0, 64'd12);
        tick();
        chk("b2b_idle", 64'(busy), 64'd0);
        go(1, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
        for (int i = 0; i < 9; i++) tick();
        chk("pre_clr_busy", 64'(busy), 64'd1);
        clr = 1;
        tick();
        clr = 0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_out", out, 64'd0);
        go(1, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
        wait_done("post_clr", 0, 64'd42);
        tick();
`ifdef BOOTH_MULT_ITER_ABORT_EN
        go(0, 32'd3, 32'd7);
        wait_done("pre_abort", 0, 64'd21);
        tick();
        go(0, 32'd5, 32'd5);
        for (int i = 0; i < 4; i++) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_out", out, 64'd21);
        begin
            int nd = 0;
            for (int i = 0; i < 20; i++) begin
                if (done) nd++;
                tick();
            end
            chk("abort_no_done", 64'(nd), 64'd0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
